// File: rtl/uc_arbiter_rr_if.sv
// uc_arbiter_rr_if: groups the unit-clause arbiter's seed, engine, broadcast and status signals.
//   clear                      synchronous restart request
//   mem_valid/mem_lit/mem_done seed literal stream; mem_ready accepts a literal
//   eng_lit/eng_empty/eng_pop  per-engine UCQ_in heads, empty flags and one-hot pop
//   out_full/mstack_full       downstream back-pressure
//   out_push/out_lit           broadcast of newly assigned literals
//   conflict/conflict_lit      sticky conflict flag and the offending literal
//   assigned_cnt               number of assigned variables
// master: the environment side; slave: the arbiter side.
interface uc_arbiter_rr_if #(
    parameter int unsigned NUM_ENGINE = 4,
    parameter int unsigned LIT_W      = 8
);
    logic                             clear;
    logic                             mem_valid;
    logic [LIT_W-1:0]                 mem_lit;
    logic                             mem_done;
    logic                             mem_ready;
    logic [NUM_ENGINE-1:0][LIT_W-1:0] eng_lit;
    logic [NUM_ENGINE-1:0]            eng_empty;
    logic [NUM_ENGINE-1:0]            eng_pop;
    logic [NUM_ENGINE-1:0]            out_full;
    logic                             mstack_full;
    logic                             out_push;
    logic [LIT_W-1:0]                 out_lit;
    logic                             conflict;
    logic [LIT_W-1:0]                 conflict_lit;
    logic [LIT_W-1:0]                 assigned_cnt;

    modport master (
        output clear, mem_valid, mem_lit, mem_done, eng_lit, eng_empty, out_full, mstack_full,
        input  mem_ready, eng_pop, out_push, out_lit, conflict, conflict_lit, assigned_cnt
    );

    modport slave (
        input  clear, mem_valid, mem_lit, mem_done, eng_lit, eng_empty, out_full, mstack_full,
        output mem_ready, eng_pop, out_push, out_lit, conflict, conflict_lit, assigned_cnt
    );
endinterface

// File: rtl/uc_arbiter_rr.sv
// uc_arbiter_rr: unit-clause arbiter. Loads seed literals, then round-robin pops engine queues,
// keeps a variable assignment table, broadcasts each new assignment once and flags conflicts.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  uc_arbiter_rr_if slave modport (seed stream, engine queues, broadcast, status)
module uc_arbiter_rr #(
    parameter int unsigned NUM_ENGINE = 4,
    parameter int unsigned LIT_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    uc_arbiter_rr_if.slave bus
);
    localparam int unsigned NUM_VARS = 2 ** (LIT_W - 1);
    localparam int unsigned VAR_W    = LIT_W - 1;
    localparam int unsigned PTR_W    = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StRun   = 2'd1,
        StConfl = 2'd2
    } state_e;

    state_e                state_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [NUM_VARS-1:0]   asg_q;
    logic [NUM_VARS-1:0]   val_q;
    logic                  push_q;
    logic [LIT_W-1:0]      lit_q;
    logic                  conflict_q;
    logic [LIT_W-1:0]      conflict_lit_q;
    logic [LIT_W-1:0]      cnt_q;

    logic                  stall;
    logic                  go;
    logic                  found;
    logic [PTR_W-1:0]      grant;
    logic                  accept;
    logic                  pop_any;
    logic                  take;
    logic [LIT_W-1:0]      sel_lit;
    logic [VAR_W-1:0]      var_idx;
    logic                  pol;
    logic                  is_new;
    logic                  is_confl;

    // First non-empty engine strictly after the last grant, wrapping.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        grant = ptr_q;
        for (int unsigned k = 1; k <= NUM_ENGINE; k++) begin
            idx = (32'(ptr_q) + k) % NUM_ENGINE;
            if (!found && !bus.eng_empty[PTR_W'(idx)]) begin
                found = 1'b1;
                grant = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        stall   = (|bus.out_full) | bus.mstack_full;
        // clear and rst suppress any handshake in their cycle.
        go      = !rst && !bus.clear && !stall;
        accept  = (state_q == StLoad) && bus.mem_valid && go;
        pop_any = (state_q == StRun) && found && go;
        take    = accept || pop_any;
        sel_lit = (state_q == StLoad) ? bus.mem_lit : bus.eng_lit[grant];
        var_idx = sel_lit[VAR_W-1:0];
        pol     = sel_lit[LIT_W-1];
        // Stored value is !polarity, so a stored value equal to polarity means opposite sign.
        is_new   = take && (var_idx != '0) && !asg_q[var_idx];
        is_confl = take && (var_idx != '0) && asg_q[var_idx] && (val_q[var_idx] == pol);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state_q        <= StLoad;
            ptr_q          <= PTR_W'(NUM_ENGINE - 1);
            asg_q          <= '0;
            val_q          <= '0;
            push_q         <= 1'b0;
            lit_q          <= '0;
            conflict_q     <= 1'b0;
            conflict_lit_q <= '0;
            cnt_q          <= '0;
        end else begin
            push_q <= is_new;
            if (is_new) begin
                asg_q[var_idx] <= 1'b1;
                val_q[var_idx] <= !pol;
                lit_q          <= sel_lit;
                if (cnt_q != LIT_W'(NUM_VARS - 1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (pop_any) begin
                ptr_q <= grant;
            end
            if (is_confl) begin
                conflict_q     <= 1'b1;
                conflict_lit_q <= sel_lit;
                state_q        <= StConfl;
            end else if ((state_q == StLoad) && bus.mem_done) begin
                state_q <= StRun;
            end
        end
    end

    assign bus.mem_ready    = accept;
    assign bus.eng_pop      = pop_any ? (NUM_ENGINE'(1) << grant) : '0;
    assign bus.out_push     = push_q;
    assign bus.out_lit      = lit_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_lit = conflict_lit_q;
    assign bus.assigned_cnt = cnt_q;
endmodule

// File: tb/tb_uc_arbiter_rr.sv
module tb_uc_arbiter_rr;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uc_arbiter_rr_if #(.NUM_ENGINE(4), .LIT_W(8)) bus ();

    uc_arbiter_rr #(.NUM_ENGINE(4), .LIT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int passes = 0;

    // Scoreboard of literals expected on the broadcast, plus a reference table.
    logic [7:0]   exp_q[$];
    logic [127:0] m_asg;
    logic [127:0] m_val;
    int           m_cnt;

    function automatic void model_clear();
        m_asg = '0;
        m_val = '0;
        m_cnt = 0;
    endfunction

    function automatic void model_apply(input logic [7:0] lit);
        logic [6:0] v;
        v = lit[6:0];
        if (v != 7'd0 && !m_asg[v]) begin
            m_asg[v] = 1'b1;
            m_val[v] = !lit[7];
            m_cnt++;
            exp_q.push_back(lit);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_push === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL push_unexpected: out_lit=%h, required no push", bus.out_lit);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.out_lit !== e) $display("FAIL push_lit: got %h want %h", bus.out_lit, e);
                else passes++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_lit = 8'h05;
        bus.eng_empty = 4'b0000;
        step();
        step();
        @(negedge clk);
        checks++;
        if (bus.mem_ready !== 1'b0) $display("FAIL rst_mem_ready: got %b want 0", bus.mem_ready);
        else passes++;
        checks++;
        if (bus.eng_pop !== 4'b0) $display("FAIL rst_eng_pop: got %b want 0000", bus.eng_pop);
        else passes++;
        step();
        rst = 1'b0;
        bus.mem_valid = 1'b0;
        bus.eng_empty = 4'b1111;
        model_clear();
        @(negedge clk);
        checks++;
        if (bus.out_push !== 1'b0) $display("FAIL rst_out_push: got %b want 0", bus.out_push);
        else passes++;
        checks++;
        if (bus.out_lit !== 8'h00) $display("FAIL rst_out_lit: got %h want 00", bus.out_lit);
        else passes++;
        checks++;
        if (bus.conflict !== 1'b0) $display("FAIL rst_conflict: got %b want 0", bus.conflict);
        else passes++;
        checks++;
        if (bus.conflict_lit !== 8'h00)
            $display("FAIL rst_conflict_lit: got %h want 00", bus.conflict_lit);
        else passes++;
        checks++;
        if (bus.assigned_cnt !== 8'h00)
            $display("FAIL rst_assigned_cnt: got %0d want 0", bus.assigned_cnt);
        else passes++;
        checks++;
        if (dut.state_q !== 2'd0) $display("FAIL rst_state: got %0d want 0", dut.state_q);
        else passes++;
    endtask

    task automatic test_seed();
        step();
        bus.mstack_full = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_lit = 8'h05;
        @(negedge clk);
        checks++;
        if (bus.mem_ready !== 1'b0) $display("FAIL load_stall: got %b want 0", bus.mem_ready);
        else passes++;
        step();
        bus.mstack_full = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_ready !== 1'b1) $display("FAIL seed_ready_05: got %b want 1", bus.mem_ready);
        else passes++;
        model_apply(8'h05);
        step();
        bus.mem_lit = 8'h83;
        bus.mem_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_ready !== 1'b1) $display("FAIL seed_ready_83: got %b want 1", bus.mem_ready);
        else passes++;
        checks++;
        if (bus.out_push !== 1'b1) $display("FAIL seed_latency_05: got %b want 1", bus.out_push);
        else passes++;
        model_apply(8'h83);
        step();
        bus.mem_valid = 1'b0;
        bus.mem_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_push !== 1'b1) $display("FAIL seed_latency_83: got %b want 1", bus.out_push);
        else passes++;
        checks++;
        if (dut.state_q !== 2'd1) $display("FAIL seed_state_run: got %0d want 1", dut.state_q);
        else passes++;
        checks++;
        if (bus.assigned_cnt !== 8'(m_cnt))
            $display("FAIL seed_cnt: got %0d want %0d", bus.assigned_cnt, m_cnt);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if (bus.out_push !== 1'b0 || bus.out_lit !== 8'h83)
            $display("FAIL push_pulse_hold: got push=%b lit=%h want push=0 lit=83",
                     bus.out_push, bus.out_lit);
        else passes++;
    endtask

    task automatic test_round_robin();
        step();
        for (int i = 0; i < 4; i++) bus.eng_lit[i] = 8'(8'h10 + i);
        bus.eng_empty = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.eng_pop !== (4'b0001 << i))
                $display("FAIL rr_order_%0d: got %b want %b", i, bus.eng_pop, 4'b0001 << i);
            else passes++;
            model_apply(8'(8'h10 + i));
            step();
            bus.eng_empty[i] = 1'b1;
        end
        bus.eng_lit[1] = 8'h21;
        bus.eng_lit[3] = 8'h23;
        bus.eng_empty = 4'b0101;
        @(negedge clk);
        checks++;
        if (bus.eng_pop !== 4'b0010) $display("FAIL rr_refill_1: got %b want 0010", bus.eng_pop);
        else passes++;
        model_apply(8'h21);
        step();
        bus.eng_empty[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.eng_pop !== 4'b1000) $display("FAIL rr_refill_3: got %b want 1000", bus.eng_pop);
        else passes++;
        model_apply(8'h23);
        step();
        bus.eng_empty[3] = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) $display("FAIL rr_pushes: %0d pushes missing, want 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_stall();
        step();
        for (int i = 0; i < 4; i++) bus.eng_lit[i] = 8'(8'h30 + i);
        bus.eng_empty = 4'b0000;
        bus.out_full = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.eng_pop !== 4'b0) $display("FAIL stall_pop_%0d: got %b want 0000", c, bus.eng_pop);
            else passes++;
            step();
        end
        bus.out_full = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.eng_pop !== (4'b0001 << i))
                $display("FAIL stall_resume_%0d: got %b want %b", i, bus.eng_pop, 4'b0001 << i);
            else passes++;
            model_apply(8'(8'h30 + i));
            step();
            bus.eng_empty[i] = 1'b1;
        end
        step();
    endtask

    task automatic test_duplicate();
        bus.eng_lit[2] = 8'h05;
        bus.eng_empty = 4'b1011;
        @(negedge clk);
        checks++;
        if (bus.eng_pop !== 4'b0100) $display("FAIL dup_pop: got %b want 0100", bus.eng_pop);
        else passes++;
        model_apply(8'h05);
        step();
        bus.eng_empty = 4'b1111;
        @(negedge clk);
        checks++;
        if (bus.out_push !== 1'b0) $display("FAIL dup_no_push: got %b want 0", bus.out_push);
        else passes++;
        checks++;
        if (bus.assigned_cnt !== 8'(m_cnt))
            $display("FAIL dup_cnt: got %0d want %0d", bus.assigned_cnt, m_cnt);
        else passes++;
    endtask

    task automatic test_conflict();
        step();
        bus.eng_lit[3] = 8'h85;
        bus.eng_empty = 4'b0111;
        @(negedge clk);
        checks++;
        if (bus.eng_pop !== 4'b1000) $display("FAIL confl_pop: got %b want 1000", bus.eng_pop);
        else passes++;
        model_apply(8'h85);
        step();
        bus.eng_lit[0] = 8'h40;
        bus.eng_empty = 4'b1110;
        bus.mem_valid = 1'b1;
        bus.mem_lit = 8'h05;
        @(negedge clk);
        checks++;
        if (bus.conflict !== 1'b1) $display("FAIL confl_flag: got %b want 1", bus.conflict);
        else passes++;
        checks++;
        if (bus.conflict_lit !== 8'h85)
            $display("FAIL confl_lit: got %h want 85", bus.conflict_lit);
        else passes++;
        checks++;
        if (bus.out_push !== 1'b0) $display("FAIL confl_no_push: got %b want 0", bus.out_push);
        else passes++;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bus.eng_pop !== 4'b0 || bus.mem_ready !== 1'b0)
                $display("FAIL confl_idle_%0d: got pop=%b ready=%b want 0000/0",
                         c, bus.eng_pop, bus.mem_ready);
            else passes++;
            step();
            @(negedge clk);
        end
        step();
        bus.clear = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.eng_pop !== 4'b0 || bus.mem_ready !== 1'b0)
            $display("FAIL clear_idle: got pop=%b ready=%b want 0000/0", bus.eng_pop, bus.mem_ready);
        else passes++;
        step();
        bus.clear = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (bus.conflict !== 1'b0 || bus.conflict_lit !== 8'h00)
            $display("FAIL clear_conflict: got %b/%h want 0/00", bus.conflict, bus.conflict_lit);
        else passes++;
        checks++;
        if (bus.assigned_cnt !== 8'h00)
            $display("FAIL clear_cnt: got %0d want 0", bus.assigned_cnt);
        else passes++;
        checks++;
        if (dut.state_q !== 2'd0) $display("FAIL clear_state: got %0d want 0", dut.state_q);
        else passes++;
        checks++;
        if (bus.eng_pop !== 4'b0) $display("FAIL load_ignores_eng: got %b want 0000", bus.eng_pop);
        else passes++;
        checks++;
        if (bus.mem_ready !== 1'b1) $display("FAIL clear_reseed: got %b want 1", bus.mem_ready);
        else passes++;
        model_apply(8'h05);
    endtask

    task automatic test_back_to_back();
        step();
        bus.mem_lit = 8'h80;
        @(negedge clk);
        model_apply(8'h80);
        step();
        bus.mem_lit = 8'h00;
        bus.mem_done = 1'b1;
        @(negedge clk);
        model_apply(8'h00);
        step();
        bus.mem_valid = 1'b0;
        bus.mem_done = 1'b0;
        bus.eng_empty = 4'b1111;
        @(negedge clk);
        checks++;
        if (dut.state_q !== 2'd1) $display("FAIL b2b_state_run: got %0d want 1", dut.state_q);
        else passes++;
        checks++;
        if (bus.assigned_cnt !== 8'(m_cnt))
            $display("FAIL var0_cnt: got %0d want %0d", bus.assigned_cnt, m_cnt);
        else passes++;
        step();
        bus.eng_lit[0] = 8'h07;
        bus.eng_lit[1] = 8'h87;
        bus.eng_empty = 4'b1100;
        @(negedge clk);
        checks++;
        if (bus.eng_pop !== 4'b0001) $display("FAIL b2b_pop0: got %b want 0001", bus.eng_pop);
        else passes++;
        model_apply(8'h07);
        step();
        bus.eng_empty[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.eng_pop !== 4'b0010) $display("FAIL b2b_pop1: got %b want 0010", bus.eng_pop);
        else passes++;
        model_apply(8'h87);
        step();
        bus.eng_empty[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.conflict !== 1'b1 || bus.conflict_lit !== 8'h87)
            $display("FAIL b2b_conflict: got %b/%h want 1/87", bus.conflict, bus.conflict_lit);
        else passes++;
        checks++;
        if (bus.assigned_cnt !== 8'(m_cnt))
            $display("FAIL b2b_cnt: got %0d want %0d", bus.assigned_cnt, m_cnt);
        else passes++;
        step();
        step();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) $display("FAIL final_pushes: %0d pushes missing, want 0", exp_q.size());
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_lit = '0;
        bus.mem_done = 1'b0;
        bus.eng_lit = '0;
        bus.eng_empty = '1;
        bus.out_full = '0;
        bus.mstack_full = 1'b0;
        model_clear();
        test_reset();
        test_seed();
        test_round_robin();
        test_stall();
        test_duplicate();
        test_conflict();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uc_arbiter_rr.md
UC_ARBITER_RR -- requirements
Module: uc_arbiter_rr

Interface
REQ-001 Parameter NUM_ENGINE, default 4: number of engine channels, range 1..16.
REQ-002 Parameter LIT_W, default 8: literal width; bit LIT_W-1 is polarity (1 = negated), bits LIT_W-2:0 are the variable index.
REQ-003 Parameter NUM_VARS = 2^(LIT_W-1) (derived); variable index 0 is reserved and never assigned.
REQ-004 clk  in  1  the single clock; every flop is on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 clear  in  1  synchronous restart: wipe the assignment table and return to LOAD.
REQ-007 mem_valid  in  1  a seed literal is present on mem_lit.
REQ-008 mem_lit  in  LIT_W  seed literal.
REQ-009 mem_done  in  1  seed stream finished.
REQ-010 mem_ready  out  1  seed literal accepted this cycle.
REQ-011 eng_lit  in  NUM_ENGINE x LIT_W  head of each engine's UCQ_in.
REQ-012 eng_empty  in  NUM_ENGINE  per-engine UCQ_in empty.
REQ-013 eng_pop  out  NUM_ENGINE  one-hot pop of the granted engine's UCQ_in.
REQ-014 out_full  in  NUM_ENGINE  per-engine UCQ_out cannot take a push next cycle.
REQ-015 mstack_full  in  1  mstack cannot take a push next cycle.
REQ-016 out_push  out  1  broadcast push to every UCQ_out and to mstack.
REQ-017 out_lit  out  LIT_W  broadcast literal.
REQ-018 conflict  out  1  sticky conflict flag.
REQ-019 conflict_lit  out  LIT_W  incoming literal that caused the conflict.
REQ-020 assigned_cnt  out  LIT_W  number of variables currently assigned.

Function
REQ-021 FSM states LOAD, RUN, CONFL; reset and clear enter LOAD.
REQ-022 stall = |out_full | mstack_full; while stall = 1, no pop, mem_ready = 0, and the table does not change.
REQ-023 LOAD: mem_ready = mem_valid & !stall (combinational); an accepted literal is processed as in REQ-026..029.
REQ-024 LOAD: mem_done = 1 moves to RUN at the next edge; a literal accepted in the same cycle is still processed.
REQ-025 RUN: grant the first engine with eng_empty = 0 after the last-granted index, wrapping modulo NUM_ENGINE; eng_pop[grant] = !stall; the pointer updates only on a pop; the pointer resets to NUM_ENGINE-1, so engine 0 has first priority.
REQ-026 Processing an unassigned variable: on the next edge, set the table entry {assigned = 1, value = !polarity}, increment assigned_cnt, and register out_push = 1 with out_lit = the literal (latency: 1 cycle after pop or accept).
REQ-027 Processing a literal whose variable is assigned with the same value: discard it; out_push stays 0.
REQ-028 Processing a literal whose variable is assigned with the opposite value: set conflict = 1 and conflict_lit = the literal, enter CONFL, no push, table unchanged.
REQ-029 Processing a literal with variable index 0: discard it; no push, no table change.
REQ-030 out_push is a one-cycle pulse; out_lit holds its last value when out_push = 0.
REQ-031 The table is updated at the edge ending the processing cycle, so a literal processed in the next cycle sees the update (back-to-back same-variable literals are handled correctly).
REQ-032 CONFL: no pops, mem_ready = 0, out_push = 0; conflict and conflict_lit hold until rst or clear.
REQ-033 mem_valid and mem_done are ignored in RUN and CONFL; eng_* inputs are ignored in LOAD and CONFL.
REQ-034 clear takes priority over all same-cycle activity: no pop or accept that cycle; the next edge zeros the table and assigned_cnt, sets conflict = 0, and enters LOAD.
REQ-035 assigned_cnt saturates at NUM_VARS-1.

Reset
REQ-036 At rst (and at clear, REQ-034): state = LOAD, table all unassigned, RR pointer = NUM_ENGINE-1, out_push = 0, out_lit = 0, conflict = 0, conflict_lit = 0, assigned_cnt = 0; eng_pop and mem_ready are 0 during rst.
REQ-037 Reset mid-operation drops any in-flight literal without a push.

Verification
REQ-038 NUM_ENGINE = 4, LIT_W = 8. Seed 0x05 then 0x83 with mem_done on the second → out_push pulses with 0x05 then 0x83 one cycle after each accept; state = RUN; assigned_cnt = 2.
REQ-039 RUN, all four engines non-empty, holding 0x10 to 0x13 → pops in order 0,1,2,3, one per cycle; a later refill of engines 1 and 3 only → grants 1 then 3.
REQ-040 Table holds var 5 = true; an engine presents 0x85 → conflict = 1 and conflict_lit = 0x85 next cycle; eng_pop = 0 afterwards; clear → conflict = 0, assigned_cnt = 0, state = LOAD.
REQ-041 Engine 2 presents 0x05 after var 5 is assigned true → popped, no out_push, assigned_cnt unchanged.
REQ-042 out_full[1] = 1 for 3 cycles with engines non-empty → zero pops during those cycles; pops resume in the first cycle after out_full[1] drops.
REQ-043 Engines 0 and 1 present 0x07 and 0x87 on consecutive grants → first pushed, second raises conflict with conflict_lit = 0x87.
